// File: rtl/uart_frame_tx.sv
`timescale 1ns/1ps
// uart_frame_tx: sends a wide board vector as one 8N1 packet made of a
// header byte, the payload bytes MSB-first, and an optional XOR checksum.
// A one-deep pending slot holds the most recent update that arrives while
// a frame is on the line.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | line idle high; waiting for a strobe
// S_START | start bit (low) of the current byte
// S_DATA  | 8 data bits of the current byte, LSB first
// S_STOP  | stop bit (high); the last cycle of the last byte ends the frame
module uart_frame_tx #(
    parameter int         DATA_W       = 192,
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] HDR_BYTE     = 8'hA5,
    parameter bit         CHECKSUM_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_stb,
    output logic              o_tx,
    output logic              o_tx_busy,
    output logic              o_pending,
    output logic              o_frame_done,
    output logic              o_overwrite
);

    localparam int NBYTES = DATA_W / 8;
    localparam int NB     = NBYTES + 1 + (CHECKSUM_EN ? 1 : 0);
    localparam int IDXW   = (NB > 1) ? $clog2(NB) : 1;
    localparam int CNTW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(CLKS_PER_BIT - 1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NB - 1);

    if ((DATA_W % 8) != 0 || DATA_W < 8 || CLKS_PER_BIT < 2) begin : g_bad_param
        $error("uart_frame_tx: DATA_W must be a non-zero multiple of 8 and CLKS_PER_BIT >= 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t            r_state;
    logic [CNTW-1:0]   r_cnt;
    logic [2:0]        r_bit_idx;
    logic [IDXW-1:0]   r_byte_idx;
    logic [6:0]        r_shift;
    logic              r_tx;
    logic [DATA_W-1:0] r_frame;
    logic [DATA_W-1:0] r_slot;
    logic              r_slot_vld;

    state_t            w_state_nxt;
    logic [CNTW-1:0]   w_cnt_nxt;
    logic [2:0]        w_bit_idx_nxt;
    logic [IDXW-1:0]   w_byte_idx_nxt;
    logic [6:0]        w_shift_nxt;
    logic              w_tx_nxt;
    logic [DATA_W-1:0] w_frame_nxt;
    logic [DATA_W-1:0] w_slot_nxt;
    logic              w_slot_vld_nxt;
    logic              w_frame_done;
    logic              w_overwrite;
    logic              w_load_start;

    logic [7:0]        w_csum;
    logic [7:0]        w_pay_byte;
    logic [7:0]        w_cur_byte;
    logic              w_bit_end;
    logic              w_last_byte;
    logic              w_frame_end;

    // Payload byte for the current index, plus the running XOR over all payload bytes
    always_comb begin
        w_csum     = '0;
        w_pay_byte = '0;
        for (int j = 0; j < NBYTES; j++) begin
            w_csum = w_csum ^ r_frame[DATA_W-1-8*j -: 8];
            if (r_byte_idx == IDXW'(j + 1)) begin
                w_pay_byte = r_frame[DATA_W-1-8*j -: 8];
            end
        end
    end

    assign w_cur_byte  = (r_byte_idx == '0)                     ? HDR_BYTE :
                         (CHECKSUM_EN && r_byte_idx == IDX_LAST) ? w_csum   :
                                                                   w_pay_byte;
    assign w_bit_end   = (r_cnt == '0);
    assign w_last_byte = (r_byte_idx == IDX_LAST);
    assign w_frame_end = (r_state == S_STOP) && w_bit_end && w_last_byte;

    // Next-state, bit timing, line value and pending-slot decisions
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_bit_idx_nxt  = r_bit_idx;
        w_byte_idx_nxt = r_byte_idx;
        w_shift_nxt    = r_shift;
        w_tx_nxt       = r_tx;
        w_frame_nxt    = r_frame;
        w_slot_nxt     = r_slot;
        w_slot_vld_nxt = r_slot_vld;
        w_frame_done   = 1'b0;
        w_overwrite    = 1'b0;
        w_load_start   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_tx_stb) begin
                    w_frame_nxt  = i_tx_data;
                    w_load_start = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt   = S_DATA;
                    w_cnt_nxt     = CNT_LOAD;
                    w_bit_idx_nxt = 3'd0;
                    w_shift_nxt   = w_cur_byte[7:1];
                    w_tx_nxt      = w_cur_byte[0];
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt = CNT_LOAD;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_tx_nxt      = r_shift[0];
                        w_shift_nxt   = {1'b0, r_shift[6:1]};
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (!w_last_byte) begin
                        w_state_nxt    = S_START;
                        w_cnt_nxt      = CNT_LOAD;
                        w_byte_idx_nxt = r_byte_idx + 1'b1;
                        w_tx_nxt       = 1'b0;
                    end else begin
                        w_frame_done = 1'b1;
                        // A strobe in the end cycle beats whatever is queued
                        if (i_tx_stb) begin
                            w_frame_nxt    = i_tx_data;
                            w_overwrite    = r_slot_vld;
                            w_slot_vld_nxt = 1'b0;
                            w_load_start   = 1'b1;
                        end else if (r_slot_vld) begin
                            w_frame_nxt    = r_slot;
                            w_slot_vld_nxt = 1'b0;
                            w_load_start   = 1'b1;
                        end else begin
                            w_state_nxt    = S_IDLE;
                            w_byte_idx_nxt = '0;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_load_start) begin
            w_state_nxt    = S_START;
            w_cnt_nxt      = CNT_LOAD;
            w_byte_idx_nxt = '0;
            w_tx_nxt       = 1'b0;
        end

        if (r_state != S_IDLE && i_tx_stb && !w_frame_end) begin
            w_slot_nxt     = i_tx_data;
            w_slot_vld_nxt = 1'b1;
            w_overwrite    = r_slot_vld;
        end
    end

    // State and datapath registers; reset abandons any frame and empties the slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_frame    <= '0;
            r_slot     <= '0;
            r_slot_vld <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
            r_frame    <= w_frame_nxt;
            r_slot     <= w_slot_nxt;
            r_slot_vld <= w_slot_vld_nxt;
        end
    end

    assign o_tx         = r_tx;
    assign o_tx_busy    = (r_state != S_IDLE);
    assign o_pending    = r_slot_vld;
    assign o_frame_done = w_frame_done;
    assign o_overwrite  = w_overwrite;

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Parametrised successor to the board UART transmit path. Accepts a wide board-state vector on a strobe and transmits it as one framed 8N1 packet: header byte, payload bytes MSB-first, then an optional XOR checksum byte.
- Adds a one-deep pending slot, so a board update that arrives mid-frame is queued instead of lost.
- Sits between the game logic (board vector, 16 tiles x 12 bits in the default configuration) and the FPGA UART TX pin.

Parameters:
- DATA_W, 192: payload width in bits. Must be a multiple of 8. NBYTES = DATA_W/8.
- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200). Minimum value 2.
- HDR_BYTE, 8'hA5: first byte of every frame.
- CHECKSUM_EN, 1: when 1, append the checksum byte; when 0, omit it.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_tx_data  in  DATA_W  board vector; sampled only in a cycle where i_tx_stb=1.
- i_tx_stb  in  1  frame request; single-cycle or level (a level is re-sampled each cycle).
- o_tx  out  1  UART TX line; idle high.
- o_tx_busy  out  1  high while a frame is being shifted out.
- o_pending  out  1  pending slot holds a queued frame.
- o_frame_done  out  1  1-cycle pulse in the last cycle of each frame's final stop bit.
- o_overwrite  out  1  1-cycle pulse when queued data is replaced or dropped.

Behaviour:
- Reset (asynchronous, any state): o_tx=1, o_tx_busy=0, o_pending=0, o_frame_done=0, o_overwrite=0, FSM=IDLE, counters=0, pending slot cleared.
  - A frame in progress is abandoned.
  - After rst deasserts, o_tx stays high until the next accepted strobe.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: i_tx_stb=1 latches i_tx_data into the frame register and loads the byte index with 0. Next cycle: START, o_tx=0, o_tx_busy=1. Latency from strobe edge to start bit is 1 cycle.
  - START: o_tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles, then STOP.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles.
    - Not the last byte: increment the byte index and go to START. There is no idle gap between bytes.
    - Last byte: frame end (see below).
- Byte sequence, index 0 to NB-1, with NB = NBYTES+1+CHECKSUM_EN:
  - index 0 = HDR_BYTE.
  - index k (1..NBYTES) = frame[DATA_W-8(k-1)-1 -: 8].
  - index NB-1 (only when CHECKSUM_EN=1) = XOR of all NBYTES payload bytes; the header is excluded.
- Frame duration is exactly 10*NB*CLKS_PER_BIT cycles, counted from the first start-bit cycle to the last stop-bit cycle.
- Pending slot (only while o_tx_busy=1):
  - i_tx_stb=1 in a non-end cycle writes the slot and sets o_pending=1.
  - If the slot was already valid, o_overwrite pulses and the latest data wins.
- Frame end (last cycle of the final stop bit): o_frame_done=1 in this cycle, then:
  - i_tx_stb=1 in this cycle: load i_tx_data directly. If o_pending=1, pulse o_overwrite and clear the slot.
  - Else if o_pending=1: load the slot and clear o_pending.
  - Else: go to IDLE; o_tx_busy falls next cycle.
  - In the two load cases, the next frame's start bit begins the following cycle and o_tx_busy stays high with no gap.
- i_tx_data changes while not strobed have no effect on the frame in flight.

Test Plan:
- Single frame (DATA_W=16, CLKS_PER_BIT=4, CHECKSUM_EN=1): i_tx_data=16'h0100 with a 1-cycle strobe -> bytes A5,01,00,01. o_tx low 1 cycle after the strobe. Busy for exactly 160 cycles. o_frame_done in the last busy cycle.
- Board frame (DATA_W=192, CLKS_PER_BIT=4): data={144'd0,12'd256,36'd0} -> 26 bytes. Byte 19 = 8'h10, byte 20 = 8'h00, all other payload bytes 00. Checksum = 8'h10. Duration 1040 cycles.
- CHECKSUM_EN=0, DATA_W=16, data 16'hFF00 -> bytes A5,FF,00 only. Duration 120 cycles.
- Queueing: strobe A, then strobe B and C mid-frame -> o_overwrite pulses once (on C). Frame C follows A with no idle cycle. B is never sent. o_pending is 0 after C starts.
- Boundary: strobe D exactly in the frame-end cycle with the slot holding B -> D is sent next, o_overwrite pulses, o_pending=0.
- Async reset mid-DATA -> o_tx=1 and all outputs 0 without waiting for a clock edge. A new strobe after reset -> a complete fresh frame.
